// File: rtl/issue_scoreboard_if.sv
// Decode/execute/write-back signal bundle for the issue scoreboard.
// The master drives the instruction stream; the slave is the scoreboard.
interface issue_scoreboard_if #(
  parameter int RDW = 5
);
  logic           valid_input;
  logic [RDW-1:0] rs1_addr;
  logic [RDW-1:0] rs2_addr;
  logic [RDW-1:0] rd_addr;
  logic           use_rs1;
  logic           use_rs2;
  logic           write_reserve;
  logic           stall_input;
  logic           wb_valid;
  logic [RDW-1:0] wb_rd_addr;
  logic           flush;
  logic           valid_output;
  logic           stall_output;
  logic           pending_any;
  logic           underflow_err;

  modport master (
    output valid_input, rs1_addr, rs2_addr, rd_addr, use_rs1, use_rs2,
           write_reserve, stall_input, wb_valid, wb_rd_addr, flush,
    input  valid_output, stall_output, pending_any, underflow_err
  );

  modport slave (
    input  valid_input, rs1_addr, rs2_addr, rd_addr, use_rs1, use_rs2,
           write_reserve, stall_input, wb_valid, wb_rd_addr, flush,
    output valid_output, stall_output, pending_any, underflow_err
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register in-flight write counters that hold decode
// while a source, or a saturated destination, still has a pending write.
module issue_scoreboard #(
  parameter int REGISTER_DESCRIPTOR_WIDTH = 5,
  parameter int PENDING_WIDTH             = 2
) (
  input  logic              clk,
  input  logic              rst,
  issue_scoreboard_if.slave bus
);
  localparam int RDW   = REGISTER_DESCRIPTOR_WIDTH;
  localparam int PW    = PENDING_WIDTH;
  localparam int NREGS = 2 ** RDW;
  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [RDW-1:0] X0  = '0;

  logic [PW-1:0] pend     [NREGS];
  logic [PW-1:0] pend_nxt [NREGS];
  logic          hz;
  logic          fire;
  logic          inc;
  logic          dec;
  logic          same_reg;
  logic          under;
  logic          any;
  logic          err;

  // Hazard looks only at registered counters: a release shows up next cycle.
  always_comb begin
    hz = (bus.use_rs1 && bus.rs1_addr != X0 && pend[bus.rs1_addr] != '0)
      || (bus.use_rs2 && bus.rs2_addr != X0 && pend[bus.rs2_addr] != '0)
      || (bus.write_reserve && bus.rd_addr != X0 && pend[bus.rd_addr] == PMAX);
  end

  assign fire     = rst && bus.valid_input && !hz && !bus.stall_input && !bus.flush;
  assign inc      = fire && bus.write_reserve && bus.rd_addr != X0;
  assign dec      = bus.wb_valid && bus.wb_rd_addr != X0;
  assign same_reg = inc && dec && bus.rd_addr == bus.wb_rd_addr;

  assign bus.valid_output = fire;
  assign bus.stall_output = rst && bus.valid_input && (hz || bus.stall_input) && !bus.flush;

  // Flush discards this cycle's reserve/release, including any underflow.
  always_comb begin
    pend_nxt = pend;
    under    = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < NREGS; i++) pend_nxt[i] = '0;
    end else begin
      if (dec && pend[bus.wb_rd_addr] == '0) under = 1'b1;
      if (inc && !same_reg) pend_nxt[bus.rd_addr] = pend[bus.rd_addr] + ONE;
      if (dec && !same_reg && pend[bus.wb_rd_addr] != '0)
        pend_nxt[bus.wb_rd_addr] = pend[bus.wb_rd_addr] - ONE;
    end
  end

  always_comb begin
    any = 1'b0;
    for (int i = 0; i < NREGS; i++) any = any | (pend[i] != '0);
  end

  assign bus.pending_any   = any;
  assign bus.underflow_err = err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
      err <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (under) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: RAW stalls, x0, saturation, same-cycle
// reserve/release, underflow, flush and reset while stalled.
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  issue_scoreboard_if #(.RDW(5)) bus ();

  issue_scoreboard #(
    .REGISTER_DESCRIPTOR_WIDTH(5),
    .PENDING_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.valid_input   = 1'b0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    bus.rd_addr       = '0;
    bus.use_rs1       = 1'b0;
    bus.use_rs2       = 1'b0;
    bus.write_reserve = 1'b0;
    bus.stall_input   = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd_addr    = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic wr(input logic [4:0] rd);
    idle();
    bus.valid_input   = 1'b1;
    bus.write_reserve = 1'b1;
    bus.rd_addr       = rd;
  endtask

  task automatic rd1(input logic [4:0] rs);
    idle();
    bus.valid_input = 1'b1;
    bus.use_rs1     = 1'b1;
    bus.rs1_addr    = rs;
  endtask

  task automatic wb(input logic [4:0] r);
    bus.wb_valid   = 1'b1;
    bus.wb_rd_addr = r;
  endtask

  // Settle combinational outputs before checking, then advance one edge.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io(input string tag, input logic v, input logic s);
    settle();
    chk({tag, ".valid"}, bus.valid_output, v);
    chk({tag, ".stall"}, bus.stall_output, s);
  endtask

  initial begin
    idle();
    // Reset with an instruction presented: outputs held low.
    wr(5'd2);
    #1;
    io("rst_hold", 1'b0, 1'b0);
    tick();
    chk("rst_pend_any", bus.pending_any, 1'b0);
    chk("rst_uerr", bus.underflow_err, 1'b0);
    rst = 1'b1;
    idle();
    tick();

    // 1: ADD x3 then SUB reading x3.
    wr(5'd3);
    io("t1_add", 1'b1, 1'b0);
    tick();
    chk("t1_pend_any", bus.pending_any, 1'b1);
    rd1(5'd3);
    io("t1_sub_stall0", 1'b0, 1'b1);
    tick();
    io("t1_sub_stall1", 1'b0, 1'b1);
    tick();
    wb(5'd3);
    io("t1_sub_wb_cycle", 1'b0, 1'b1);
    tick();
    rd1(5'd3);
    io("t1_sub_issue", 1'b1, 1'b0);
    tick();
    chk("t1_pend_clear", bus.pending_any, 1'b0);
    rd1(5'd3);
    bus.stall_input = 1'b1;
    io("t1_exec_stall", 1'b0, 1'b1);
    idle();
    tick();

    // 2: x0 is never reserved and never blocks.
    wr(5'd0);
    io("t2_addi_x0", 1'b1, 1'b0);
    tick();
    chk("t2_pend_any0", bus.pending_any, 1'b0);
    rd1(5'd0);
    io("t2_read_x0", 1'b1, 1'b0);
    tick();
    chk("t2_pend_any1", bus.pending_any, 1'b0);

    // 3: saturate x5.
    wr(5'd5);
    io("t3_w1", 1'b1, 1'b0);
    tick();
    wr(5'd5);
    io("t3_w2", 1'b1, 1'b0);
    tick();
    wr(5'd5);
    io("t3_w3", 1'b1, 1'b0);
    tick();
    wr(5'd5);
    io("t3_w4_sat", 1'b0, 1'b1);
    tick();
    wr(5'd5);
    wb(5'd5);
    io("t3_w4_wb_cycle", 1'b0, 1'b1);
    tick();
    wr(5'd5);
    io("t3_w4_issue", 1'b1, 1'b0);
    tick();
    wr(5'd5);
    io("t3_w5_sat_again", 1'b0, 1'b1);
    idle();
    wb(5'd5);
    tick();
    wb(5'd5);
    tick();
    wb(5'd5);
    tick();
    idle();
    settle();
    chk("t3_drained", bus.pending_any, 1'b0);
    chk("t3_no_uerr", bus.underflow_err, 1'b0);
    tick();

    // 4: reserve and release of x7 in the same cycle leaves pend[7]=1.
    wr(5'd7);
    tick();
    wr(5'd7);
    wb(5'd7);
    io("t4_issue_with_wb", 1'b1, 1'b0);
    tick();
    rd1(5'd7);
    io("t4_still_pending", 1'b0, 1'b1);
    wb(5'd7);
    tick();
    idle();
    settle();
    chk("t4_pend_any0", bus.pending_any, 1'b0);
    chk("t4_no_uerr", bus.underflow_err, 1'b0);
    tick();

    // 5: release of an idle register is an underflow.
    wb(5'd9);
    tick();
    idle();
    settle();
    chk("t5_uerr_set", bus.underflow_err, 1'b1);
    chk("t5_pend_any", bus.pending_any, 1'b0);
    tick();
    tick();
    chk("t5_uerr_sticky", bus.underflow_err, 1'b1);

    // 6: flush while a read of x4 is stalled.
    wr(5'd4);
    tick();
    wr(5'd4);
    tick();
    rd1(5'd4);
    io("t6_stalled", 1'b0, 1'b1);
    bus.flush = 1'b1;
    io("t6_flush_cycle", 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("t6_pend_cleared", bus.pending_any, 1'b0);
    chk("t6_uerr_kept", bus.underflow_err, 1'b1);
    rd1(5'd4);
    io("t6_read_after_flush", 1'b1, 1'b0);
    tick();

    // Reset while stalled drops the instruction and its blocker.
    wr(5'd6);
    tick();
    rd1(5'd6);
    io("rst_mid_stalled", 1'b0, 1'b1);
    rst = 1'b0;
    io("rst_mid_outputs", 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    settle();
    chk("rst_mid_pend", bus.pending_any, 1'b0);
    chk("rst_mid_uerr", bus.underflow_err, 1'b0);
    io("rst_mid_reissue", 1'b1, 1'b0);
    tick();
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
